// File: rtl/clk_meter_pkg.sv
// Shared definitions for the sample-rate checker and its edge front end.
// FSM state encoding used by clk_period_meter.
`timescale 1ns/1ps
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Purpose: 2-FF synchronizer on an async input plus registered rising-edge pulse.
// Latency: rise sampled at edge k gives rise pulse high after edge k+2.
// Backpressure: none; free-running, produces a single-cycle pulse per rise.
`timescale 1ns/1ps
module sync_edge_det (
  input  logic clk,
  input  logic i_rst,
  input  logic async_in,
  output logic rise
);

  logic sync_q1;
  logic sync_q2;
  logic sync_q3;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      sync_q3 <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
      rise    <= sync_q2 & ~sync_q3;
    end
  end

endmodule

// File: rtl/clk_period_meter.sv
// Purpose: measures the period of an async clock-like input in clk cycles, flags lock/timeout.
// Latency: o_valid/o_period one cycle after the synchronized edge pulse; outputs registered.
// Backpressure: none; o_valid and o_timeout are single-cycle pulses with no ready.
`timescale 1ns/1ps
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MAX_PERIOD = 4095,
  parameter int TOL        = 2,
  parameter int LOCK_N     = 4
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             enable,
  input  logic             i_clk_meas,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] TOL_CNT  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_N);
  localparam logic [RUN_W-1:0] ONE_RUN  = RUN_W'(1);

  logic rise;

  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .i_rst    (i_rst),
    .async_in (i_clk_meas),
    .rise     (rise)
  );

  meter_state_t     state,    state_nxt;
  logic [CNT_W-1:0] cnt,      cnt_nxt;
  logic [CNT_W-1:0] prev,     prev_nxt;
  logic [RUN_W-1:0] run,      run_nxt;
  logic             has_prev, has_prev_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             valid_nxt;
  logic             locked_nxt;
  logic             timeout_nxt;
  logic [CNT_W-1:0] diff;
  logic             stable;

  // Unsigned max-min so the comparison never wraps.
  always_comb begin
    diff   = (cnt > prev) ? (cnt - prev) : (prev - cnt);
    stable = has_prev && (diff <= TOL_CNT);
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    prev_nxt     = prev;
    run_nxt      = run;
    has_prev_nxt = has_prev;
    period_nxt   = o_period;
    valid_nxt    = 1'b0;
    timeout_nxt  = 1'b0;
    locked_nxt   = o_locked;

    if (!enable) begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      run_nxt      = '0;
      has_prev_nxt = 1'b0;
      locked_nxt   = 1'b0;
    end else begin
      unique case (state)
        IDLE: state_nxt = ARM;
        ARM: begin
          // First edge after arming only starts the count; no period yet.
          if (rise) begin
            cnt_nxt      = ONE_CNT;
            has_prev_nxt = 1'b0;
            state_nxt    = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_nxt   = cnt;
            valid_nxt    = 1'b1;
            cnt_nxt      = ONE_CNT;
            prev_nxt     = cnt;
            has_prev_nxt = 1'b1;
            if (stable) begin
              run_nxt = (run == LOCK_RUN) ? run : (run + ONE_RUN);
            end else begin
              run_nxt = '0;
            end
            locked_nxt = (run_nxt == LOCK_RUN);
          end else if (cnt >= MAX_CNT) begin
            timeout_nxt = 1'b1;
            locked_nxt  = 1'b0;
            run_nxt     = '0;
            cnt_nxt     = '0;
            state_nxt   = ARM;
          end else begin
            cnt_nxt = cnt + ONE_CNT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      prev      <= '0;
      run       <= '0;
      has_prev  <= 1'b0;
      o_period  <= '0;
      o_valid   <= 1'b0;
      o_locked  <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      prev      <= prev_nxt;
      run       <= run_nxt;
      has_prev  <= has_prev_nxt;
      o_period  <= period_nxt;
      o_valid   <= valid_nxt;
      o_locked  <= locked_nxt;
      o_timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int MAXP  = 100;
  localparam int TOLV  = 2;
  localparam int LOCKN = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable = 1'b0;
  logic             meas = 1'b0;
  logic [CNT_W-1:0] o_period;
  logic             o_valid;
  logic             o_locked;
  logic             o_timeout;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .MAX_PERIOD (MAXP),
    .TOL        (TOLV),
    .LOCK_N     (LOCKN)
  ) dut (
    .clk        (clk),
    .i_rst      (rst_n),
    .enable     (enable),
    .i_clk_meas (meas),
    .o_period   (o_period),
    .o_valid    (o_valid),
    .o_locked   (o_locked),
    .o_timeout  (o_timeout)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Measured-signal generator: rises always land 7 ns past a 40 ns boundary.
  int cyc = 0;
  int meas_period = 26;
  int per_q[$];
  int e_q[$];

  initial begin
    int p;
    #7;
    forever begin
      if (per_q.size() > 0) p = per_q.pop_front();
      else p = meas_period;
      if (p == 0) begin
        #40;
      end else begin
        meas = 1'b1;
        // Sampled at the next clk edge, edge pulse visible two cycles later.
        if (rst_n) e_q.push_back(cyc + 3);
        #(p * 20);
        meas = 1'b0;
        #(p * 20);
      end
    end
  end

  // Reference model: periods are differences of edge-pulse timestamps.
  typedef enum {M_OFF, M_ARM, M_MEAS} mmode_t;
  mmode_t mode = M_OFF;
  int  last_e = 0;
  int  prev_p = 0;
  int  run_m = 0;
  bit  have_prev = 1'b0;
  bit  exp_valid = 1'b0;
  bit  exp_timeout = 1'b0;
  bit  exp_locked = 1'b0;
  int  exp_period = 0;

  always @(posedge clk or negedge rst_n) begin
    bit e;
    int p;
    int d;
    if (!rst_n) begin
      mode = M_OFF; last_e = 0; prev_p = 0; run_m = 0; have_prev = 1'b0;
      exp_valid = 1'b0; exp_timeout = 1'b0; exp_locked = 1'b0; exp_period = 0;
      e_q.delete();
    end else begin
      cyc++;
      e = 1'b0;
      while (e_q.size() > 0 && e_q[0] < cyc - 1) void'(e_q.pop_front());
      if (e_q.size() > 0 && e_q[0] == cyc - 1) begin
        e = 1'b1;
        void'(e_q.pop_front());
      end
      exp_valid = 1'b0;
      exp_timeout = 1'b0;
      if (!enable) begin
        mode = M_OFF; run_m = 0; have_prev = 1'b0; exp_locked = 1'b0;
      end else begin
        case (mode)
          M_OFF: mode = M_ARM;
          M_ARM: if (e) begin
            mode = M_MEAS; last_e = cyc - 1; have_prev = 1'b0;
          end
          M_MEAS: begin
            if (e) begin
              p = cyc - 1 - last_e;
              last_e = cyc - 1;
              exp_valid = 1'b1;
              exp_period = p;
              d = (p > prev_p) ? p - prev_p : prev_p - p;
              if (!have_prev) run_m = 0;
              else if (d <= TOLV) run_m = (run_m + 1 > LOCKN) ? LOCKN : run_m + 1;
              else run_m = 0;
              prev_p = p;
              have_prev = 1'b1;
              exp_locked = (run_m == LOCKN);
            end else if (cyc - 1 - last_e == MAXP) begin
              exp_timeout = 1'b1; exp_locked = 1'b0; run_m = 0; mode = M_ARM;
            end
          end
          default: mode = M_OFF;
        endcase
      end
    end
  end

  // Per-cycle compare plus a log of every observed pulse.
  bit vlock [0:1023];
  int vper  [0:1023];
  int vcyc  [0:1023];
  int valid_cnt = 0;
  int tcnt = 0;
  int tcyc = 0;

  always @(negedge clk) begin
    chk("cyc_valid",   {31'd0, o_valid},   {31'd0, exp_valid});
    chk("cyc_timeout", {31'd0, o_timeout}, {31'd0, exp_timeout});
    chk("cyc_locked",  {31'd0, o_locked},  {31'd0, exp_locked});
    chk("cyc_period",  {16'd0, o_period},  exp_period);
    if (o_valid && valid_cnt < 1024) begin
      vlock[valid_cnt] = o_locked;
      vper[valid_cnt]  = int'(o_period);
      vcyc[valid_cnt]  = cyc;
      valid_cnt++;
    end
    if (o_timeout) begin
      tcnt++;
      tcyc = cyc;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int first_lock(input int base);
    for (int i = base; i < valid_cnt; i++) if (vlock[i]) return i - base + 1;
    return -1;
  endfunction

  function automatic int find_period(input int base, input int p);
    for (int i = base; i < valid_cnt; i++) if (vper[i] == p) return i;
    return -1;
  endfunction

  initial begin
    int b;
    int idx;
    int tc;
    int en_cyc;

    // Asynchronous reset takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #8;
    chk("rst_valid",   {31'd0, o_valid},   0);
    chk("rst_timeout", {31'd0, o_timeout}, 0);
    chk("rst_locked",  {31'd0, o_locked},  0);
    chk("rst_period",  {16'd0, o_period},  0);
    #80 rst_n = 1'b1;
    #310 enable = 1'b1;

    // 1: steady 26-cycle input locks on the fifth valid.
    b = valid_cnt;
    wait_clks(26 * 10);
    chk("t1_nvalid_ge6", (valid_cnt - b >= 6) ? 32'd1 : 32'd0, 1);
    chk("t1_period", vper[b], 26);
    chk("t1_lock_idx", first_lock(b), 5);

    // 2: jitter keeps lock, a 30 breaks it, five valids later it returns.
    b = valid_cnt;
    per_q.push_back(27); per_q.push_back(26); per_q.push_back(27);
    per_q.push_back(26); per_q.push_back(30);
    wait_clks(26 * 14);
    idx = find_period(b, 30);
    chk("t2_seen30", (idx >= 0) ? 32'd1 : 32'd0, 1);
    if (idx > 0) begin
      chk("t2_jitter_locked", {31'd0, vlock[idx-1]}, 1);
      chk("t2_break",         {31'd0, vlock[idx]},   0);
      chk("t2_relock_4",      {31'd0, vlock[idx+4]}, 0);
      chk("t2_relock_5",      {31'd0, vlock[idx+5]}, 1);
    end

    // 3: input stalls, timeout exactly MAXP cycles after the last edge.
    tc = tcnt;
    meas_period = 0;
    wait_clks(300);
    chk("t3_timeouts", tcnt - tc, 1);
    chk("t3_gap", tcyc - vcyc[valid_cnt-1], 100);
    chk("t3_period_held", {16'd0, o_period}, 26);
    chk("t3_locked", {31'd0, o_locked}, 0);
    b = valid_cnt;
    meas_period = 26;
    wait_clks(26 * 4);
    chk("t3_restart_period", vper[b], 26);

    // 4: a period of exactly MAXP is a legal measurement.
    tc = tcnt;
    b = valid_cnt;
    meas_period = 100;
    wait_clks(450);
    chk("t4_seen100", (find_period(b, 100) >= 0) ? 32'd1 : 32'd0, 1);
    chk("t4_no_timeout", tcnt - tc, 0);

    // 5: disable mid-period, then re-enable.
    meas_period = 26;
    wait_clks(26 * 10);
    chk("t5_locked_before", {31'd0, o_locked}, 1);
    wait_clks(9);
    enable = 1'b0;
    wait_clks(2);
    chk("t5_locked_off", {31'd0, o_locked}, 0);
    chk("t5_period_kept", {16'd0, o_period}, 26);
    wait_clks(100);
    b = valid_cnt;
    enable = 1'b1;
    en_cyc = cyc;
    wait_clks(26 * 4);
    chk("t5_first_valid_late", (valid_cnt > b && vcyc[b] - en_cyc >= 27) ? 32'd1 : 32'd0, 1);
    chk("t5_first_period", vper[b], 26);

    // 6: async reset while the input is low, mid-measurement.
    wait_clks(26 * 6);
    @(posedge meas);
    #600 rst_n = 1'b0;
    #1;
    chk("t6_valid",   {31'd0, o_valid},   0);
    chk("t6_timeout", {31'd0, o_timeout}, 0);
    chk("t6_locked",  {31'd0, o_locked},  0);
    chk("t6_period",  {16'd0, o_period},  0);
    #199 rst_n = 1'b1;
    b = valid_cnt;
    wait_clks(26 * 9);
    chk("t6_lock_idx", first_lock(b), 5);
    chk("t6_period_after", vper[b], 26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
